// File: rtl/rf_hazard_pipe_if.sv
// Decode/writeback bus between the pipeline control and the hazard unit.
// The master drives the decode-stage instruction fields and observes the
// stall request and writeback controls; the slave is the hazard pipe.
interface rf_hazard_pipe_if #(
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              ID_VALID;
    logic [ADDR_W-1:0] Rsrc1;
    logic [ADDR_W-1:0] Rsrc2;
    logic              USE_SRC1;
    logic              USE_SRC2;
    logic [ADDR_W-1:0] Rdst_in;
    logic              WR_IN;
    logic              FLUSH;
    logic              STALL;
    logic [ADDR_W-1:0] Rdst;
    logic              RF_WRITE;
    logic [ADDR_W-1:0] Rdst_E;
    logic [ADDR_W-1:0] Rdst_M;
    logic [CNT_W-1:0]  STALL_CNT;

    modport master (
        output ID_VALID, Rsrc1, Rsrc2, USE_SRC1, USE_SRC2, Rdst_in, WR_IN, FLUSH,
        input  STALL, Rdst, RF_WRITE, Rdst_E, Rdst_M, STALL_CNT
    );

    modport slave (
        input  ID_VALID, Rsrc1, Rsrc2, USE_SRC1, USE_SRC2, Rdst_in, WR_IN, FLUSH,
        output STALL, Rdst, RF_WRITE, Rdst_E, Rdst_M, STALL_CNT
    );
endinterface

// File: rtl/rf_hazard_pipe.sv
// Destination tracker and RAW hazard detector for a 5-stage pipeline.
// Carries {valid, wr, dst} from decode through execute and memory to
// writeback, drives the register file write port from the writeback slot,
// and stalls decode while any in-flight producer still owes a write to a
// register the decode instruction reads. The writeback slot counts as a
// hazard because the register file write and the decode read land on the
// same edge, so the read would still see the old value.
module rf_hazard_pipe #(
    parameter int ADDR_W  = 5,
    parameter int CNT_W   = 16,
    parameter bit R0_ZERO = 1'b1
) (
    input logic             clk,
    input logic             rst_n,
    rf_hazard_pipe_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic              wr;
        logic [ADDR_W-1:0] dst;
    } slot_t;

    slot_t            s3;
    slot_t            s4;
    slot_t            s5;
    logic [CNT_W-1:0] stall_cnt;

    logic live3;
    logic live4;
    logic live5;
    logic hz1;
    logic hz2;
    logic stall;

    // A slot only matters if it really writes; register 0 is inert when hardwired.
    function automatic logic is_live(input slot_t s);
        return s.valid & s.wr & ~(R0_ZERO & (s.dst == '0));
    endfunction

    assign live3 = is_live(s3);
    assign live4 = is_live(s4);
    assign live5 = is_live(s5);

    // Compare each used source against every in-flight live destination.
    always_comb begin
        hz1 = 1'b0;
        hz2 = 1'b0;
        if (bus.USE_SRC1) begin
            hz1 = (live3 && (s3.dst == bus.Rsrc1)) ||
                  (live4 && (s4.dst == bus.Rsrc1)) ||
                  (live5 && (s5.dst == bus.Rsrc1));
        end
        if (bus.USE_SRC2) begin
            hz2 = (live3 && (s3.dst == bus.Rsrc2)) ||
                  (live4 && (s4.dst == bus.Rsrc2)) ||
                  (live5 && (s5.dst == bus.Rsrc2));
        end
    end

    // A flushed or empty decode slot never stalls.
    assign stall = bus.ID_VALID & ~bus.FLUSH & (hz1 | hz2);

    // Advance the slots every cycle; decode inserts a bubble on stall, flush or no instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3 <= '0;
            s4 <= '0;
            s5 <= '0;
        end else begin
            s5       <= s4;
            s4       <= s3;
            s3.valid <= bus.ID_VALID & ~bus.FLUSH & ~stall;
            s3.wr    <= bus.WR_IN;
            s3.dst   <= bus.Rdst_in;
        end
    end

    // Count stalled cycles, holding at the maximum instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.STALL     = stall;
    assign bus.RF_WRITE  = live5;
    assign bus.Rdst      = s5.dst;
    assign bus.Rdst_E    = s3.dst;
    assign bus.Rdst_M    = s4.dst;
    assign bus.STALL_CNT = stall_cnt;

endmodule

// File: tb/tb_rf_hazard_pipe.sv
// Directed bench for rf_hazard_pipe. Three copies share one stimulus stream:
// the default build, one with register 0 writable, and one with a 2-bit
// stall counter. Each check targets whichever copy exhibits the behaviour.
module tb_rf_hazard_pipe;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] rsrc1;
    logic [4:0] rsrc2;
    logic       use_src1;
    logic       use_src2;
    logic [4:0] rdst_in;
    logic       wr_in;
    logic       flush;

    int total;
    int bad;
    int exp_cnt_main;
    int exp_cnt_r0;

    rf_hazard_pipe_if #(.ADDR_W(5), .CNT_W(16)) bus_main ();
    rf_hazard_pipe_if #(.ADDR_W(5), .CNT_W(16)) bus_r0 ();
    rf_hazard_pipe_if #(.ADDR_W(5), .CNT_W(2))  bus_sat ();

    rf_hazard_pipe #(.ADDR_W(5), .CNT_W(16), .R0_ZERO(1'b1)) dut_main (
        .clk(clk), .rst_n(rst_n), .bus(bus_main.slave)
    );
    rf_hazard_pipe #(.ADDR_W(5), .CNT_W(16), .R0_ZERO(1'b0)) dut_r0 (
        .clk(clk), .rst_n(rst_n), .bus(bus_r0.slave)
    );
    rf_hazard_pipe #(.ADDR_W(5), .CNT_W(2), .R0_ZERO(1'b1)) dut_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_sat.slave)
    );

    assign bus_main.ID_VALID = id_valid;
    assign bus_main.Rsrc1    = rsrc1;
    assign bus_main.Rsrc2    = rsrc2;
    assign bus_main.USE_SRC1 = use_src1;
    assign bus_main.USE_SRC2 = use_src2;
    assign bus_main.Rdst_in  = rdst_in;
    assign bus_main.WR_IN    = wr_in;
    assign bus_main.FLUSH    = flush;

    assign bus_r0.ID_VALID = id_valid;
    assign bus_r0.Rsrc1    = rsrc1;
    assign bus_r0.Rsrc2    = rsrc2;
    assign bus_r0.USE_SRC1 = use_src1;
    assign bus_r0.USE_SRC2 = use_src2;
    assign bus_r0.Rdst_in  = rdst_in;
    assign bus_r0.WR_IN    = wr_in;
    assign bus_r0.FLUSH    = flush;

    assign bus_sat.ID_VALID = id_valid;
    assign bus_sat.Rsrc1    = rsrc1;
    assign bus_sat.Rsrc2    = rsrc2;
    assign bus_sat.USE_SRC1 = use_src1;
    assign bus_sat.USE_SRC2 = use_src2;
    assign bus_sat.Rdst_in  = rdst_in;
    assign bus_sat.WR_IN    = wr_in;
    assign bus_sat.FLUSH    = flush;

    // Free-running clock, posedges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Count one comparison and report it if the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present one decode-stage instruction for the next cycle, then wait to mid-cycle.
    task automatic applyStimulus(input logic v, input logic [4:0] s1, input logic u1,
                                 input logic [4:0] s2, input logic u2,
                                 input logic [4:0] d, input logic wr, input logic fl);
        @(posedge clk);
        #1;
        id_valid = v;
        rsrc1    = s1;
        use_src1 = u1;
        rsrc2    = s2;
        use_src2 = u2;
        rdst_in  = d;
        wr_in    = wr;
        flush    = fl;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    // Producer to R7, d-1 non-writing fillers, then a consumer of R7 via source 2.
    task automatic run_distance(input int d, input int n_stall);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
        for (int k = 1; k < d; k++) applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        for (int k = 0; k <= n_stall; k++) begin
            applyStimulus(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd0, 1'b0, 1'b0);
            checkOutput($sformatf("dist%0d_stall_c%0d", d, k), bus_main.STALL, (k < n_stall));
        end
        exp_cnt_main += n_stall;
        exp_cnt_r0   += n_stall;
        idle(4);
        checkOutput($sformatf("dist%0d_cnt", d), bus_main.STALL_CNT, exp_cnt_main);
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_cnt_main = 0;
        exp_cnt_r0 = 0;
        id_valid = 1'b0; rsrc1 = '0; rsrc2 = '0; use_src1 = 1'b0; use_src2 = 1'b0;
        rdst_in = '0; wr_in = 1'b0; flush = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_rf_write", bus_main.RF_WRITE, 0);
        checkOutput("rst_rdst", bus_main.Rdst, 0);
        checkOutput("rst_rdst_e", bus_main.Rdst_E, 0);
        checkOutput("rst_rdst_m", bus_main.Rdst_M, 0);
        checkOutput("rst_cnt", bus_main.STALL_CNT, 0);
        checkOutput("rst_stall", bus_main.STALL, 0);
        #19 rst_n = 1'b1;

        // Adjacent RAW on R5; consumer writes R6 so its entry into the pipe is visible.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
        checkOutput("adj_c0_stall", bus_main.STALL, 0);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        checkOutput("adj_c1_stall", bus_main.STALL, 1);
        checkOutput("adj_c1_rdst_e", bus_main.Rdst_E, 5);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        checkOutput("adj_c2_stall", bus_main.STALL, 1);
        checkOutput("adj_c2_rdst_m", bus_main.Rdst_M, 5);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        checkOutput("adj_c3_stall", bus_main.STALL, 1);
        checkOutput("adj_c3_rf_write", bus_main.RF_WRITE, 1);
        checkOutput("adj_c3_rdst", bus_main.Rdst, 5);
        applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
        exp_cnt_main = 3;
        exp_cnt_r0 = 3;
        checkOutput("adj_c4_stall", bus_main.STALL, 0);
        checkOutput("adj_c4_cnt", bus_main.STALL_CNT, exp_cnt_main);
        checkOutput("adj_c4_cnt_sat", bus_sat.STALL_CNT, 3);
        idle(1);
        checkOutput("adj_c5_rf_write", bus_main.RF_WRITE, 0);
        idle(1);
        checkOutput("adj_c6_rf_write", bus_main.RF_WRITE, 0);
        idle(1);
        checkOutput("adj_c7_rf_write", bus_main.RF_WRITE, 1);
        checkOutput("adj_c7_rdst", bus_main.Rdst, 6);
        idle(1);
        checkOutput("adj_c8_rf_write", bus_main.RF_WRITE, 0);
        idle(2);

        // Distance sweep on R7; the 2-bit counter passes five stalls here and must hold.
        run_distance(2, 2);
        checkOutput("sat_cnt_hold", bus_sat.STALL_CNT, 3);
        run_distance(3, 1);
        run_distance(4, 0);

        // Register 0: inert in the default build, a real producer when writable.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("r0_c1_stall_main", bus_main.STALL, 0);
        checkOutput("r0_c1_stall_r0", bus_r0.STALL, 1);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("r0_c2_stall_r0", bus_r0.STALL, 1);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("r0_c3_stall_r0", bus_r0.STALL, 1);
        checkOutput("r0_c3_rf_write_main", bus_main.RF_WRITE, 0);
        checkOutput("r0_c3_rf_write_r0", bus_r0.RF_WRITE, 1);
        checkOutput("r0_c3_rdst_r0", bus_r0.Rdst, 0);
        applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("r0_c4_stall_r0", bus_r0.STALL, 0);
        exp_cnt_r0 += 3;
        idle(4);
        checkOutput("r0_cnt_main", bus_main.STALL_CNT, exp_cnt_main);
        checkOutput("r0_cnt_r0", bus_r0.STALL_CNT, exp_cnt_r0);

        // Matching addresses with both use flags low must not stall.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("mask_c1_stall", bus_main.STALL, 0);
        applyStimulus(1'b1, 5'd12, 1'b0, 5'd12, 1'b0, 5'd0, 1'b0, 1'b0);
        checkOutput("mask_c2_stall", bus_main.STALL, 0);
        idle(4);

        // Flush in the first hazard cycle: no stall, no count, bubble, producer still writes.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
        checkOutput("flush_c1_stall", bus_main.STALL, 0);
        idle(1);
        checkOutput("flush_c2_cnt", bus_main.STALL_CNT, exp_cnt_main);
        idle(1);
        checkOutput("flush_c3_rf_write", bus_main.RF_WRITE, 1);
        checkOutput("flush_c3_rdst", bus_main.Rdst, 9);
        idle(1);
        checkOutput("flush_c4_rf_write", bus_main.RF_WRITE, 0);
        idle(3);

        // Four independent writers back to back.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
        checkOutput("b2b_c1_rdst_e", bus_main.Rdst_E, 1);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
        checkOutput("b2b_c2_rdst_e", bus_main.Rdst_E, 2);
        checkOutput("b2b_c2_rdst_m", bus_main.Rdst_M, 1);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
        checkOutput("b2b_c3_rf_write", bus_main.RF_WRITE, 1);
        checkOutput("b2b_c3_rdst", bus_main.Rdst, 1);
        for (int i = 2; i <= 4; i++) begin
            idle(1);
            checkOutput($sformatf("b2b_w%0d_rf_write", i), bus_main.RF_WRITE, 1);
            checkOutput($sformatf("b2b_w%0d_rdst", i), bus_main.Rdst, i);
        end
        idle(1);
        checkOutput("b2b_end_rf_write", bus_main.RF_WRITE, 0);
        idle(3);

        // Asynchronous reset with writes in flight and a pending hazard on R13.
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
        applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b0, 1'b0);
        idle(1);
        checkOutput("arst_pre_rf_write", bus_main.RF_WRITE, 1);
        checkOutput("arst_pre_rdst", bus_main.Rdst, 11);
        checkOutput("arst_pre_rdst_m", bus_main.Rdst_M, 13);
        id_valid = 1'b1;
        rsrc1 = 5'd13;
        use_src1 = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_rf_write", bus_main.RF_WRITE, 0);
        checkOutput("arst_rdst", bus_main.Rdst, 0);
        checkOutput("arst_rdst_m", bus_main.Rdst_M, 0);
        checkOutput("arst_rdst_e", bus_main.Rdst_E, 0);
        checkOutput("arst_stall", bus_main.STALL, 0);
        checkOutput("arst_cnt", bus_main.STALL_CNT, 0);
        checkOutput("arst_cnt_r0", bus_r0.STALL_CNT, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            idle(1);
            checkOutput($sformatf("arst_post_c%0d_rf_write", i), bus_main.RF_WRITE, 0);
        end
        checkOutput("arst_post_cnt", bus_main.STALL_CNT, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
